// File: rtl/parking_car_emulator.sv
// Stimulus generator for the gate sensor decoder: plays a/b photo-sensor phases of a car crossing.
// Optional lot-occupancy tracking and command refusal is built when PARKING_OCC_EN is defined.
module parking_car_emulator #(
  parameter int HOLD_W   = 8,
  parameter int CAPACITY = 200,
  parameter int OCC_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic              cmd_dir,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              cmd_ready,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done,
  output logic              reject,
  output logic [OCC_W-1:0]  occupancy,
  output logic              full,
  output logic              empty
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    GAP  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              dir_q, dir_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              reject_q, reject_d;
  logic              accept_s;
  logic              refuse_s;

`ifdef PARKING_OCC_EN
  localparam logic [OCC_W-1:0] CAP_C = OCC_W'(CAPACITY);

  logic [OCC_W-1:0] occ_q, occ_d;

  // A refused command still completes the handshake but never leaves IDLE
  assign refuse_s = (!cmd_dir && (occ_q == CAP_C)) || (cmd_dir && (occ_q == {OCC_W{1'b0}}));
  assign occupancy = occ_q;
  assign full      = (occ_q == CAP_C);
  assign empty     = (occ_q == {OCC_W{1'b0}});
`else
  logic [31:0] unused_cap_s;

  assign unused_cap_s = 32'(CAPACITY);
  assign refuse_s     = 1'b0;
  assign occupancy    = {OCC_W{1'b0}};
  assign full         = 1'b0;
  assign empty        = 1'b0;
`endif

  assign accept_s = cmd_valid & ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    reject_d = 1'b0;
`ifdef PARKING_OCC_EN
    occ_d    = occ_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          dir_d  = cmd_dir;
          hold_d = cmd_hold;
          if (refuse_s) begin
            reject_d = 1'b1;
          end else begin
            state_d = PH1;
            cnt_d   = cmd_hold;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PH1: begin
        if (cnt_q == {HOLD_W{1'b0}}) begin
          state_d = PH2;
          cnt_d   = hold_q;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      PH2: begin
        if (cnt_q == {HOLD_W{1'b0}}) begin
          state_d = PH3;
          cnt_d   = hold_q;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      PH3: begin
        // Leaving PH3 is the moment the car has cleared both beams
        if (cnt_q == {HOLD_W{1'b0}}) begin
          state_d = GAP;
          cnt_d   = hold_q;
          done_d  = 1'b1;
`ifdef PARKING_OCC_EN
          if (dir_q) begin
            occ_d = occ_q - OCC_W'(1);
          end else begin
            occ_d = occ_q + OCC_W'(1);
          end
`endif
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == {HOLD_W{1'b0}}) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {HOLD_W{1'b0}};
      end
    endcase
  end

  // Output pattern is derived from the next state so a/b change on the same edge as the state
  always_comb begin
    a_d = 1'b0;
    b_d = 1'b0;
    case (state_d)
      PH1: begin
        a_d = ~dir_d;
        b_d = dir_d;
      end
      PH2: begin
        a_d = 1'b1;
        b_d = 1'b1;
      end
      PH3: begin
        a_d = dir_d;
        b_d = ~dir_d;
      end
      default: begin
        a_d = 1'b0;
        b_d = 1'b0;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= {HOLD_W{1'b0}};
      hold_q   <= {HOLD_W{1'b0}};
      dir_q    <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      dir_q    <= dir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      reject_q <= reject_d;
    end
  end

`ifdef PARKING_OCC_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_q <= {OCC_W{1'b0}};
    end else begin
      occ_q <= occ_d;
    end
  end
`endif

  assign cmd_ready = ready_q;
  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign reject    = reject_q;

endmodule

// File: tb/tb_parking_car_emulator.sv
// Scoreboard bench for parking_car_emulator; covers occupancy checks when PARKING_OCC_EN is defined.
module tb_parking_car_emulator;

  localparam int HOLD_W = 8;
  localparam int OCC_W  = 8;
  localparam int CAP    = 2;
`ifdef PARKING_OCC_EN
  localparam bit OCC_EN = 1'b1;
`else
  localparam bit OCC_EN = 1'b0;
`endif

  typedef struct packed {
    logic             a;
    logic             b;
    logic             ready;
    logic             busy;
    logic             done;
    logic             reject;
    logic [OCC_W-1:0] occ;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_dir;
  logic [HOLD_W-1:0] cmd_hold;
  logic              cmd_ready;
  logic              a;
  logic              b;
  logic              busy;
  logic              done;
  logic              reject;
  logic [OCC_W-1:0]  occupancy;
  logic              full;
  logic              empty;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   m_occ   = 0;

  parking_car_emulator #(.HOLD_W(HOLD_W), .CAPACITY(CAP), .OCC_W(OCC_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_hold(cmd_hold),
    .cmd_ready(cmd_ready), .a(a), .b(b), .busy(busy), .done(done), .reject(reject),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
  endtask

  function automatic exp_t mk(input logic [1:0] ab, input logic rdy, input logic dn,
                              input logic rj, input int occ);
    exp_t e;
    e.a      = ab[1];
    e.b      = ab[0];
    e.ready  = rdy;
    e.busy   = ~rdy;
    e.done   = dn;
    e.reject = rj;
    e.occ    = OCC_EN ? OCC_W'(occ) : '0;
    return e;
  endfunction

  // Advance one clock, sample 1 time unit later and compare with the oldest expectation
  task automatic step_check(input bit drop_valid, input bit scramble);
    exp_t e;
    @(posedge clk);
    #1;
    if (drop_valid) cmd_valid = 1'b0;
    if (scramble) begin
      cmd_dir  = ~cmd_dir;
      cmd_hold = HOLD_W'($urandom_range(0, 255));
    end
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("a", {31'd0, a}, {31'd0, e.a});
      chk("b", {31'd0, b}, {31'd0, e.b});
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e.ready});
      chk("busy", {31'd0, busy}, {31'd0, e.busy});
      chk("done", {31'd0, done}, {31'd0, e.done});
      chk("reject", {31'd0, reject}, {31'd0, e.reject});
      chk("occupancy", {24'd0, occupancy}, {24'd0, e.occ});
      chk("full", {31'd0, full}, {31'd0, OCC_EN && (e.occ == OCC_W'(CAP))});
      chk("empty", {31'd0, empty}, {31'd0, OCC_EN && (e.occ == '0)});
    end
  endtask

  // Issue one command at a point where cmd_ready is high and push its expected cycle trace
  task automatic push_cmd(input logic dir, input int hold, output int n);
    logic [1:0] pat[4];
    int         new_occ;
    int         ph;
    bit         refuse;
    refuse    = OCC_EN && ((!dir && m_occ == CAP) || (dir && m_occ == 0));
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_hold  = HOLD_W'(hold);
    if (refuse) begin
      exp_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b1, m_occ));
      exp_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, m_occ));
      n = 2;
    end else begin
      pat[0]  = dir ? 2'b01 : 2'b10;
      pat[1]  = 2'b11;
      pat[2]  = dir ? 2'b10 : 2'b01;
      pat[3]  = 2'b00;
      new_occ = OCC_EN ? (dir ? m_occ - 1 : m_occ + 1) : 0;
      for (int k = 1; k <= 4 * hold + 4; k++) begin
        ph = (k - 1) / (hold + 1);
        exp_q.push_back(mk(pat[ph], 1'b0, k == 3 * hold + 4, 1'b0, (ph == 3) ? new_occ : m_occ));
      end
      exp_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, new_occ));
      m_occ = new_occ;
      n = 4 * hold + 5;
    end
  endtask

  task automatic run_cmd(input logic dir, input int hold, input bit keep_valid);
    int n;
    push_cmd(dir, hold, n);
    for (int i = 0; i < n; i++) begin
      step_check(!keep_valid || (i == n - 1 && n == 2), keep_valid && n != 2);
    end
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b0;
    cmd_hold  = '0;

    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 0));
      step_check(1'b0, 1'b0);
    end
    reset = 1'b1;

    run_cmd(1'b0, 0, 1'b0);
    run_cmd(1'b1, 2, 1'b0);
    run_cmd(1'b0, 1, 1'b1);
    run_cmd(1'b0, 0, 1'b0);
    run_cmd(1'b0, 0, 1'b0);
    run_cmd(1'b1, 0, 1'b0);
    run_cmd(1'b1, 1, 1'b0);
    run_cmd(1'b1, 0, 1'b0);

    // Reset in the first PH2 cycle (cycle H+2 with H=3)
    push_cmd(1'b0, 3, n);
    for (int i = 0; i < 5; i++) begin
      step_check(1'b1, 1'b0);
    end
    exp_q.delete();
    m_occ = 0;
    reset = 1'b0;
    exp_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 0));
    step_check(1'b0, 1'b0);
    reset = 1'b1;
    exp_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 0));
    exp_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 0));
    step_check(1'b0, 1'b0);
    step_check(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/parking_car_emulator.md
Name: parking_car_emulator

Overview:
Drives the two parking-gate photo-sensor lines (a, b) through the four-phase pattern of a car crossing the gate. An enter command produces ab = 10, 11, 01, 00; an exit command produces ab = 01, 11, 10, 00.
Sits on the stimulus side of the gate sensor decoder: it feeds the decoder's a/b inputs in FPGA self-test and in bench loopback.
Accepts one crossing command at a time through a valid/ready handshake and has a programmable per-phase hold time.

Parameters:
HOLD_W, 8, width of the per-phase hold count
CAPACITY, 200, maximum lot occupancy (used only with occupancy tracking); must be ≤ 2^OCC_W-1
OCC_W, 8, width of the occupancy counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 clears the block at the clk edge)
cmd_valid  input  1  crossing command valid
cmd_dir  input  1  0 = enter, 1 = exit
cmd_hold  input  HOLD_W  phase hold; each phase lasts cmd_hold+1 cycles
cmd_ready  output  1  block idle; can accept a command
a  output  1  sensor A line (registered)
b  output  1  sensor B line (registered)
busy  output  1  sequence in progress
done  output  1  one-cycle pulse when the crossing completes
reject  output  1  one-cycle pulse when a command is refused (occupancy feature only)
occupancy  output  OCC_W  cars currently in the lot
full  output  1  occupancy == CAPACITY
empty  output  1  occupancy == 0

Behaviour:
- Reset values (reset==0 at a clk edge): state IDLE, a=0, b=0, cmd_ready=1, busy=0, done=0, reject=0, occupancy=0, empty=1, full=0.
- Reset dominates every other input.
- Reset mid-sequence forces ab=00 on the next edge with no done pulse. The downstream decoder may see a spurious edge; that is accepted behaviour.
- cmd_ready=1 only in IDLE.
- A command is accepted when cmd_valid & cmd_ready. On acceptance, cmd_dir and cmd_hold are latched into dir_q and hold_q. cmd_valid in any other state is ignored and has no side effect.
- States: IDLE, PH1, PH2, PH3, GAP. All outputs are registered.
- Phase patterns:
  - PH1: ab = 10 (enter) / 01 (exit)
  - PH2: ab = 11
  - PH3: ab = 01 (enter) / 10 (exit)
  - GAP and IDLE: ab = 00
- Each of PH1, PH2, PH3, GAP lasts exactly hold_q+1 cycles. A down-counter is loaded with hold_q on state entry; the state advances when the counter reaches 0. hold_q=0 gives one cycle per phase.
- Timeline for an accept at edge 0 with H = hold_q:
  - PH1 occupies cycles 1..H+1
  - PH2 occupies cycles H+2..2H+2
  - PH3 occupies cycles 2H+3..3H+3
  - GAP occupies cycles 3H+4..4H+4
  - cmd_ready returns at cycle 4H+5
- Back-to-back commands therefore always present at least H+1 cycles of 00 between crossings.
- done pulses on the first GAP cycle, the same cycle ab first reads 00.
- busy=1 in PH1..GAP.
- Only one of done/reject is ever high in a given cycle.

Optional Feature:
Macro: PARKING_OCC_EN
- Defined:
  - Occupancy counter is live. It increments on done of an enter and decrements on done of an exit, in the same cycle as done.
  - Enter while full, or exit while empty: the command is accepted but no sequence runs. reject pulses one cycle later, state stays IDLE, cmd_ready stays 1, a/b stay 00, occupancy is unchanged.
  - full and empty are combinational from occupancy.
- Undefined:
  - No counter logic is built.
  - occupancy=0, full=0, empty=0 constant.
  - reject=0 constant.
  - Every accepted command runs its sequence.

Test Plan:
- Reset: hold reset=0 for 3 cycles with cmd_valid=1 → ab=00, cmd_ready=1, done=0 throughout. After release, the first accept occurs on the next edge.
- Enter, hold=0: accept at edge 0 → ab = 10, 11, 01, 00 on cycles 1-4, done=1 on cycle 4, cmd_ready=1 on cycle 5. With the feature enabled, occupancy goes 0→1 on cycle 4.
- Exit, hold=2: accept → ab = 01 ×3, 11 ×3, 10 ×3, 00 ×3 cycles, done on the first 00 cycle, cmd_ready 13 cycles after accept.
- Busy rejection: assert cmd_valid continuously with alternating cmd_dir during a sequence → only the first command runs. The next command is accepted exactly when cmd_ready rises; no pattern corruption.
- PARKING_OCC_EN, CAPACITY=2:
  - enter, enter → full=1
  - third enter → reject pulse, ab stays 00, occupancy=2
  - exit ×2 → empty=1
  - further exit → reject
- Reset mid-PH2 (ab=11) → ab=00 on the next edge, no done, occupancy=0, state IDLE.
